// File: rtl/pwm_pkg.sv
// Shared push-button / PWM definitions: debounce FSM state encodings and
// default timing constants for the push-button front end.
package pwm_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,   // stable low
        WAIT_HI = 2'd1,   // qualifying a rising level
        PRESSED = 2'd2,   // stable high
        WAIT_LO = 2'd3    // qualifying a falling level
    } db_state_t;

    localparam int unsigned DB_CYCLES_DEF  = 50000;
    localparam int unsigned CNT_W_DEF      = 16;
    localparam int unsigned RPT_DELAY_DEF  = 25000;
    localparam int unsigned RPT_PERIOD_DEF = 10000;

endpackage : pwm_pkg

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous single-bit inputs such as push-buttons.
// Both flops clear on the synchronous active-high reset.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic r_meta;
    logic r_sync;

    // Two-stage capture of the asynchronous input.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= d;
            r_sync <= r_meta;
        end
    end

    assign q = r_sync;

endmodule : sync_2ff

// File: rtl/btn_debounce.sv
// Push-button debouncer: 2FF synchronizer, four-state qualification FSM,
// registered one-cycle press/release pulses and a debounced level.
// Optional feature: define BTN_AUTOREPEAT_EN to emit repeated btn_press
// pulses while the button is held (RPT_DELAY, then every RPT_PERIOD).
module btn_debounce
    import pwm_pkg::*;
#(
    parameter int unsigned DB_CYCLES  = DB_CYCLES_DEF,
    parameter int unsigned CNT_W      = CNT_W_DEF,
    parameter int unsigned RPT_DELAY  = RPT_DELAY_DEF,
    parameter int unsigned RPT_PERIOD = RPT_PERIOD_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic btn_level,
    output logic btn_press,
    output logic btn_release
);

    // Reject configurations whose constants cannot be held in the counter.
    if ((DB_CYCLES < 2) || ((DB_CYCLES >> CNT_W) != 0) ||
        ((RPT_DELAY >> CNT_W) != 0) || ((RPT_PERIOD >> CNT_W) != 0)) begin : g_cfg_err
        $error("btn_debounce: DB_CYCLES/RPT_DELAY/RPT_PERIOD do not fit CNT_W or DB_CYCLES < 2");
    end

    localparam logic [CNT_W-1:0] LP_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] LP_DB_LAST = CNT_W'(DB_CYCLES - 1);

    logic             w_sync;
    db_state_t        r_state;
    db_state_t        w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_press;
    logic             w_press_nxt;
    logic             r_release;
    logic             w_release_nxt;
    logic             w_db_done;

`ifdef BTN_AUTOREPEAT_EN
    localparam logic [CNT_W-1:0] LP_RPT_DLY_LAST = CNT_W'(RPT_DELAY - 1);
    localparam logic [CNT_W-1:0] LP_RPT_PER_LAST = CNT_W'(RPT_PERIOD - 1);

    // 0: waiting out the initial hold delay, 1: in the periodic phase.
    logic r_rpt_phase;
    logic w_rpt_phase_nxt;
`endif

    sync_2ff u_sync (
        .clk (clk),
        .rst (rst),
        .d   (btn_raw),
        .q   (w_sync)
    );

    assign w_db_done = (r_cnt == LP_DB_LAST);

    // Next-state, counter and pulse decode; cnt is shared with the repeat timer in PRESSED.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_press_nxt   = 1'b0;
        w_release_nxt = 1'b0;
`ifdef BTN_AUTOREPEAT_EN
        w_rpt_phase_nxt = r_rpt_phase;
`endif
        case (r_state)
            IDLE: begin
                if (w_sync) begin
                    w_state_nxt = WAIT_HI;
                    w_cnt_nxt   = '0;
                end
            end
            WAIT_HI: begin
                if (!w_sync) begin
                    w_state_nxt = IDLE;
                end else if (w_db_done) begin
                    w_state_nxt = PRESSED;
                    w_cnt_nxt   = '0;
                    w_press_nxt = 1'b1;
`ifdef BTN_AUTOREPEAT_EN
                    w_rpt_phase_nxt = 1'b0;
`endif
                end else begin
                    w_cnt_nxt = r_cnt + LP_ONE;
                end
            end
            PRESSED: begin
                if (!w_sync) begin
                    w_state_nxt = WAIT_LO;
                    w_cnt_nxt   = '0;
                end
`ifdef BTN_AUTOREPEAT_EN
                else if (!r_rpt_phase) begin
                    if (r_cnt == LP_RPT_DLY_LAST) begin
                        w_press_nxt     = 1'b1;
                        w_cnt_nxt       = '0;
                        w_rpt_phase_nxt = 1'b1;
                    end else begin
                        w_cnt_nxt = r_cnt + LP_ONE;
                    end
                end else begin
                    if (r_cnt == LP_RPT_PER_LAST) begin
                        w_press_nxt = 1'b1;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + LP_ONE;
                    end
                end
`endif
            end
            WAIT_LO: begin
                if (w_sync) begin
                    w_state_nxt = PRESSED;
                    w_cnt_nxt   = '0;
`ifdef BTN_AUTOREPEAT_EN
                    w_rpt_phase_nxt = 1'b0;
`endif
                end else if (w_db_done) begin
                    w_state_nxt   = IDLE;
                    w_cnt_nxt     = '0;
                    w_release_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + LP_ONE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // State, counter and registered pulse outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
`ifdef BTN_AUTOREPEAT_EN
            r_rpt_phase <= 1'b0;
`endif
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_press   <= w_press_nxt;
            r_release <= w_release_nxt;
`ifdef BTN_AUTOREPEAT_EN
            r_rpt_phase <= w_rpt_phase_nxt;
`endif
        end
    end

    assign btn_level   = (r_state == PRESSED) || (r_state == WAIT_LO);
    assign btn_press   = r_press;
    assign btn_release = r_release;

endmodule : btn_debounce
